// File: rtl/assoc_cachemem.sv
// N-way set-associative cache storage with tree pseudo-LRU replacement, per-line dirty bits,
// a registered dirty-victim eviction port and tag invalidate.
module assoc_cachemem #(
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4,
    parameter int TAG_BITS  = 8,
    parameter int DATA_BITS = 64,
    localparam int IDX_BITS = $clog2(NUM_SETS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [IDX_BITS-1:0]  rd_idx,
    input  logic [TAG_BITS-1:0]  rd_tag,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_hit,
    output logic                 rd_dirty,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_dirty,
    input  logic                 inv_en,
    input  logic [IDX_BITS-1:0]  inv_idx,
    input  logic [TAG_BITS-1:0]  inv_tag,
    output logic                 evict_valid,
    output logic [IDX_BITS-1:0]  evict_idx,
    output logic [TAG_BITS-1:0]  evict_tag,
    output logic [DATA_BITS-1:0] evict_data
);

    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int PLRU_BITS = NUM_WAYS - 1;

    typedef logic [WAY_BITS-1:0]  way_t;
    typedef logic [PLRU_BITS-1:0] plru_t;

    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_d [NUM_SETS];
    logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_BITS-1:0]  tag_d   [NUM_SETS][NUM_WAYS];
    logic [DATA_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [DATA_BITS-1:0] data_d  [NUM_SETS][NUM_WAYS];
    plru_t                plru_q  [NUM_SETS];
    plru_t                plru_d  [NUM_SETS];

    logic                 evict_valid_q, evict_valid_d;
    logic [IDX_BITS-1:0]  evict_idx_q,   evict_idx_d;
    logic [TAG_BITS-1:0]  evict_tag_q,   evict_tag_d;
    logic [DATA_BITS-1:0] evict_data_q,  evict_data_d;

    // Tree walk from the root: a 0 bit selects the lower half, a 1 bit the upper half.
    function automatic way_t plru_victim(input plru_t bits);
        way_t  way;
        plru_t sh;
        logic  b;
        int    node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            sh   = bits >> node;
            b    = sh[0];
            way  = way_t'(way << 1) | way_t'(b);
            node = 2 * node + 1 + int'(b);
        end
        return way;
    endfunction

    // Every node on the path of way w is pointed away from w; off-path bits are kept.
    function automatic plru_t plru_touch(input plru_t bits, input way_t w);
        plru_t res;
        plru_t mask;
        way_t  wt;
        logic  b;
        int    node;
        res  = bits;
        node = 0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            wt   = w >> (WAY_BITS - 1 - lvl);
            b    = wt[0];
            mask = plru_t'(1) << node;
            if (b) res = res & ~mask;
            else   res = res | mask;
            node = 2 * node + 1 + int'(b);
        end
        return res;
    endfunction

    logic rd_hit_w;
    way_t rd_way;
    logic wr_hit, wr_any_inv, inv_hit;
    way_t wr_hit_way, wr_inv_way, wr_victim, wr_way, inv_way;

    // Downward loops so the lowest matching way ends up selected when duplicates exist.
    always_comb begin
        rd_hit_w   = 1'b0;
        rd_way     = '0;
        wr_hit     = 1'b0;
        wr_hit_way = '0;
        wr_any_inv = 1'b0;
        wr_inv_way = '0;
        inv_hit    = 1'b0;
        inv_way    = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
                rd_hit_w = 1'b1;
                rd_way   = way_t'(w);
            end
            if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
                wr_hit     = 1'b1;
                wr_hit_way = way_t'(w);
            end
            if (!valid_q[wr_idx][w]) begin
                wr_any_inv = 1'b1;
                wr_inv_way = way_t'(w);
            end
            if (valid_q[inv_idx][w] && tag_q[inv_idx][w] == inv_tag) begin
                inv_hit = 1'b1;
                inv_way = way_t'(w);
            end
        end
        wr_victim = plru_victim(plru_q[wr_idx]);
        wr_way    = wr_hit ? wr_hit_way : (wr_any_inv ? wr_inv_way : wr_victim);
    end

    assign rd_hit   = rd_hit_w;
    assign rd_data  = rd_hit_w ? data_q[rd_idx][rd_way] : '0;
    assign rd_dirty = rd_hit_w & dirty_q[rd_idx][rd_way];

    // NOTE: every target of this block is given its full default first, so no latch can form.
    always_comb begin
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        data_d        = data_q;
        plru_d        = plru_q;
        evict_valid_d = 1'b0;
        evict_idx_d   = evict_idx_q;
        evict_tag_d   = evict_tag_q;
        evict_data_d  = evict_data_q;

        // Invalidate is applied before the write so a same-line write leaves it valid.
        if (inv_en && inv_hit) begin
            valid_d[inv_idx][inv_way] = 1'b0;
            dirty_d[inv_idx][inv_way] = 1'b0;
        end

        if (rd_en && rd_hit_w) begin
            plru_d[rd_idx] = plru_touch(plru_d[rd_idx], rd_way);
        end

        if (wr_en) begin
            valid_d[wr_idx][wr_way] = 1'b1;
            tag_d[wr_idx][wr_way]   = wr_tag;
            data_d[wr_idx][wr_way]  = wr_data;
            dirty_d[wr_idx][wr_way] = wr_hit ? (dirty_q[wr_idx][wr_way] | wr_dirty) : wr_dirty;
            plru_d[wr_idx]          = plru_touch(plru_d[wr_idx], wr_way);
            if (!wr_hit && !wr_any_inv && dirty_q[wr_idx][wr_victim]) begin
                evict_valid_d = 1'b1;
                evict_idx_d   = wr_idx;
                evict_tag_d   = tag_q[wr_idx][wr_victim];
                evict_data_d  = data_q[wr_idx][wr_victim];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the whole array is cleared on reset because stale tags/data must never be observable.
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
            evict_valid_q <= 1'b0;
            evict_idx_q   <= '0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
        end else begin
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            tag_q         <= tag_d;
            data_q        <= data_d;
            plru_q        <= plru_d;
            evict_valid_q <= evict_valid_d;
            evict_idx_q   <= evict_idx_d;
            evict_tag_q   <= evict_tag_d;
            evict_data_q  <= evict_data_d;
        end
    end

    assign evict_valid = evict_valid_q;
    assign evict_idx   = evict_idx_q;
    assign evict_tag   = evict_tag_q;
    assign evict_data  = evict_data_q;

endmodule
